// File: rtl/fir_coef_bank_ctrl_pkg.sv
// fir_pkg: shared types and size derivations for the FIR coefficient bank controller.
package fir_pkg;

  localparam int FIR_COEF_WIDTH = 18;
  localparam int FIR_DSP_NR     = 32;
  localparam int FIR_TM         = 2;
  localparam int FIR_FLUSH_LAT  = 40;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    FLUSH      = 2'd2
  } fir_state_e;

  typedef logic signed [FIR_COEF_WIDTH-1:0] fir_coef_t;

  // Ceiling log2 that never returns less than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Total coefficient count across all TDM slots.
  function automatic int calc_coefs_nr(input int tm, input int dsp_nr);
    return tm * dsp_nr;
  endfunction

  // Width of the TDM slot counter.
  function automatic int calc_cw(input int tm);
    return clog2_min1(tm);
  endfunction

endpackage

// File: rtl/fir_coef_bank_ctrl_coef_bank.sv
// coef_bank: two coefficient banks, one active and one shadow.
// Writes land in the shadow bank; the active bank is presented flattened.
// With FIR_COEF_COPYBACK_EN defined, a swap also copies the set going live
// into the bank leaving service, so the new shadow starts as the running set.
module coef_bank
  import fir_pkg::*;
#(
  parameter int COEF_WIDTH = FIR_COEF_WIDTH,
  parameter int COEFS_NR   = FIR_TM * FIR_DSP_NR,
  parameter int IDXW       = clog2_min1(FIR_TM * FIR_DSP_NR)
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_wr_en,
  input  logic [IDXW-1:0]                i_wr_idx,
  input  logic [COEF_WIDTH-1:0]          i_wr_data,
  input  logic                           i_swap,
  input  logic                           i_bank_sel,
  output logic [COEFS_NR*COEF_WIDTH-1:0] o_coefs_active
);

  logic [COEF_WIDTH-1:0] r_bank [2][COEFS_NR];

`ifndef FIR_COEF_COPYBACK_EN
  logic w_unused_swap;
  assign w_unused_swap = i_swap;
`endif

  // Bank storage: shadow writes, optional copy of the incoming set on a swap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < COEFS_NR; k++) begin
          r_bank[b][k] <= '0;
        end
      end
    end else begin
      if (i_wr_en) begin
        r_bank[~i_bank_sel][i_wr_idx] <= i_wr_data;
      end
`ifdef FIR_COEF_COPYBACK_EN
      if (i_swap) begin
        for (int k = 0; k < COEFS_NR; k++) begin
          r_bank[i_bank_sel][k] <= r_bank[~i_bank_sel][k];
        end
      end
`endif
    end
  end

  // Flatten the active bank onto the output bus.
  always_comb begin
    o_coefs_active = '0;
    for (int k = 0; k < COEFS_NR; k++) begin
      o_coefs_active[k*COEF_WIDTH +: COEF_WIDTH] = r_bank[i_bank_sel][k];
    end
  end

endmodule

// File: rtl/fir_coef_bank_ctrl.sv
// fir_coef_bank_ctrl: double-buffered FIR coefficient bank controller.
// Writes go to the shadow bank while idle. A commit waits for the last TDM
// slot, swaps banks on that edge, then mutes the FIR output for FLUSH_LAT
// cycles and pulses commit_ack. All outputs decode registered state only.
// Build option: FIR_COEF_COPYBACK_EN (see coef_bank).
module fir_coef_bank_ctrl
  import fir_pkg::*;
#(
  parameter int COEF_WIDTH = FIR_COEF_WIDTH,
  parameter int DSP_NR     = FIR_DSP_NR,
  parameter int TM         = FIR_TM,
  parameter int FLUSH_LAT  = FIR_FLUSH_LAT,
  parameter int CW         = calc_cw(TM),
  parameter int AW         = clog2_min1(TM * DSP_NR)
) (
  input  logic                            fir_clk,
  input  logic                            fir_aresetn,
  input  logic [CW-1:0]                   count,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [AW-1:0]                   wr_addr,
  input  logic [COEF_WIDTH-1:0]           wr_data,
  input  logic                            commit_req,
  output logic                            commit_ack,
  output logic                            busy,
  output logic                            bank_sel,
  output logic                            mute,
  output logic                            addr_err,
  output logic [TM*DSP_NR*COEF_WIDTH-1:0] coefs_active
);

  localparam int COEFS_NR = calc_coefs_nr(TM, DSP_NR);
  localparam int IDXW     = clog2_min1(COEFS_NR);
  localparam int FCW      = clog2_min1(FLUSH_LAT);
  localparam logic [CW-1:0]  LAST_SLOT  = CW'(TM - 1);
  localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_LAT - 1);

  fir_state_e       r_state;
  fir_state_e       w_next_state;
  logic [FCW-1:0]   r_flush_cnt;
  logic             r_bank_sel;
  logic             r_commit_ack;
  logic             r_addr_err;
  logic             w_wr_fire;
  logic             w_addr_ok;
  logic             w_swap;
  logic             w_flush_done;
  logic [IDXW-1:0]  w_wr_idx;

  // The address bus may be wider than the bank index; anything past the
  // last coefficient is flagged rather than aliased.
  assign w_addr_ok    = (32'(wr_addr) < 32'(COEFS_NR));
  assign w_wr_idx     = wr_addr[IDXW-1:0];
  assign w_wr_fire    = wr_valid && (r_state == IDLE);
  assign w_swap       = (r_state == WAIT_FRAME) && (count == LAST_SLOT);
  assign w_flush_done = (r_state == FLUSH) && (r_flush_cnt == '0);

  // State register.
  always_ff @(posedge fir_clk or negedge fir_aresetn) begin
    if (!fir_aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (commit_req) w_next_state = WAIT_FRAME;
        else            w_next_state = IDLE;
      end
      WAIT_FRAME: begin
        if (w_swap) w_next_state = FLUSH;
        else        w_next_state = WAIT_FRAME;
      end
      FLUSH: begin
        if (w_flush_done) w_next_state = IDLE;
        else              w_next_state = FLUSH;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Output decode from the state register.
  always_comb begin
    wr_ready = 1'b0;
    busy     = 1'b0;
    mute     = 1'b0;
    case (r_state)
      IDLE: begin
        wr_ready = 1'b1;
        busy     = 1'b0;
        mute     = 1'b0;
      end
      WAIT_FRAME: begin
        wr_ready = 1'b0;
        busy     = 1'b1;
        mute     = 1'b0;
      end
      FLUSH: begin
        wr_ready = 1'b0;
        busy     = 1'b1;
        mute     = 1'b1;
      end
      default: begin
        wr_ready = 1'b0;
        busy     = 1'b1;
        mute     = 1'b1;
      end
    endcase
  end

  // Flush countdown, active-bank pointer, completion pulse and sticky address error.
  always_ff @(posedge fir_clk or negedge fir_aresetn) begin
    if (!fir_aresetn) begin
      r_flush_cnt  <= '0;
      r_bank_sel   <= 1'b0;
      r_commit_ack <= 1'b0;
      r_addr_err   <= 1'b0;
    end else begin
      r_commit_ack <= w_flush_done;
      if (w_swap) begin
        r_flush_cnt <= FLUSH_LOAD;
        r_bank_sel  <= ~r_bank_sel;
      end else if ((r_state == FLUSH) && (r_flush_cnt != '0)) begin
        r_flush_cnt <= r_flush_cnt - FCW'(1);
      end
      if (w_flush_done) begin
        r_addr_err <= 1'b0;
      end else if (w_wr_fire && !w_addr_ok) begin
        r_addr_err <= 1'b1;
      end
    end
  end

  assign commit_ack = r_commit_ack;
  assign bank_sel   = r_bank_sel;
  assign addr_err   = r_addr_err;

  coef_bank #(
    .COEF_WIDTH (COEF_WIDTH),
    .COEFS_NR   (COEFS_NR),
    .IDXW       (IDXW)
  ) u_coef_bank (
    .i_clk          (fir_clk),
    .i_rst_n        (fir_aresetn),
    .i_wr_en        (w_wr_fire && w_addr_ok),
    .i_wr_idx       (w_wr_idx),
    .i_wr_data      (wr_data),
    .i_swap         (w_swap),
    .i_bank_sel     (r_bank_sel),
    .o_coefs_active (coefs_active)
  );

endmodule

// File: tb/tb_fir_coef_bank_ctrl.sv
// Testbench for fir_coef_bank_ctrl: random writes and commits checked against
// an array model of the active/shadow sets and commit timing derived from
// the slot counter. Expectations follow FIR_COEF_COPYBACK_EN when defined.
`timescale 1ns/1ps
module tb_fir_coef_bank_ctrl;

  localparam int CWID = 18;
  localparam int DSPN = 32;
  localparam int TMF  = 2;
  localparam int FL   = 40;
  localparam int NR   = TMF * DSPN;
  localparam int CWB  = 1;
  localparam int AWB  = 7;  // one bit wider than the bank index so out-of-range writes can be driven

  logic                 fir_clk = 1'b0;
  logic                 fir_aresetn;
  logic [CWB-1:0]       count;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [AWB-1:0]       wr_addr;
  logic [CWID-1:0]      wr_data;
  logic                 commit_req;
  logic                 commit_ack;
  logic                 busy;
  logic                 bank_sel;
  logic                 mute;
  logic                 addr_err;
  logic [NR*CWID-1:0]   coefs_active;

  int n_total = 0;
  int n_bad   = 0;

  logic [CWID-1:0] m_active [NR];
  logic [CWID-1:0] m_shadow [NR];
  logic            m_bank;
  logic            m_err;

  fir_coef_bank_ctrl #(
    .COEF_WIDTH (CWID),
    .DSP_NR     (DSPN),
    .TM         (TMF),
    .FLUSH_LAT  (FL),
    .CW         (CWB),
    .AW         (AWB)
  ) dut (
    .fir_clk      (fir_clk),
    .fir_aresetn  (fir_aresetn),
    .count        (count),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .commit_req   (commit_req),
    .commit_ack   (commit_ack),
    .busy         (busy),
    .bank_sel     (bank_sel),
    .mute         (mute),
    .addr_err     (addr_err),
    .coefs_active (coefs_active)
  );

  always #5 fir_clk = ~fir_clk;

  function automatic logic [NR*CWID-1:0] exp_vec();
    logic [NR*CWID-1:0] v;
    for (int k = 0; k < NR; k++) v[k*CWID +: CWID] = m_active[k];
    return v;
  endfunction

  function automatic int first_diff(input logic [NR*CWID-1:0] a, input logic [NR*CWID-1:0] b);
    for (int k = 0; k < NR; k++) if (a[k*CWID +: CWID] !== b[k*CWID +: CWID]) return k;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NR; k++) begin
      m_active[k] = '0;
      m_shadow[k] = '0;
    end
    m_bank = 1'b0;
    m_err  = 1'b0;
  endtask

  // Shadow set goes live; the retired set becomes the shadow (or a copy of the live set).
  task automatic model_swap();
    logic [CWID-1:0] tmp [NR];
    for (int k = 0; k < NR; k++) begin
      tmp[k]      = m_active[k];
      m_active[k] = m_shadow[k];
`ifdef FIR_COEF_COPYBACK_EN
      m_shadow[k] = m_active[k];
`else
      m_shadow[k] = tmp[k];
`endif
    end
    m_bank = ~m_bank;
  endtask

  task automatic step();
    @(posedge fir_clk);
    #1;
    if (count == CWB'(TMF - 1)) count = '0;
    else                        count = count + CWB'(1);
  endtask

  task automatic do_reset();
    fir_aresetn = 1'b0;
    wr_valid    = 1'b0;
    commit_req  = 1'b0;
    repeat (3) step();
    fir_aresetn = 1'b1;
    model_reset();
    step();
  endtask

  task automatic do_write(input int addr, input logic [CWID-1:0] data);
    wr_valid = 1'b1;
    wr_addr  = AWB'(addr);
    wr_data  = data;
    n_total++;
    if (wr_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL write_ready got=%b exp=1", wr_ready);
    end
    step();
    wr_valid = 1'b0;
    if (addr < NR) m_shadow[addr] = data;
    else           m_err = 1'b1;
  endtask

  // Commit from idle, checking every cycle until a few cycles past the ack.
  task automatic commit_run(input bit poke, output int ack_at);
    int w;
    int d;
    logic [NR*CWID-1:0] ev;
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    w = TMF - int'(count);
    ack_at = -1;
    for (int n = 1; n <= TMF + FL + 4; n++) begin
      bit e_mute;
      bit e_ack;
      bit e_busy;
      e_mute = (n >= w + 1) && (n <= w + FL);
      e_ack  = (n == w + FL + 1);
      e_busy = (n <= w + FL);
      if (n == w + 1) model_swap();
      if (e_ack) m_err = 1'b0;
      commit_req = (poke && (n == w + 3)) ? 1'b1 : 1'b0;
      wr_valid   = e_busy ? 1'($urandom_range(0, 1)) : 1'b0;
      wr_addr    = AWB'($urandom_range(0, NR - 1));
      wr_data    = CWID'($urandom);
      n_total++;
      if (mute !== e_mute) begin
        n_bad++;
        $display("FAIL commit_mute cyc=%0d got=%b exp=%b", n, mute, e_mute);
      end
      n_total++;
      if (commit_ack !== e_ack) begin
        n_bad++;
        $display("FAIL commit_ack cyc=%0d got=%b exp=%b", n, commit_ack, e_ack);
      end
      n_total++;
      if ((busy !== e_busy) || (wr_ready !== !e_busy)) begin
        n_bad++;
        $display("FAIL commit_busy cyc=%0d got=%b/%b exp=%b/%b", n, busy, wr_ready, e_busy, !e_busy);
      end
      if ((n == w) || (n == w + 1) || e_ack) begin
        ev = exp_vec();
        n_total++;
        if ((coefs_active !== ev) || (bank_sel !== m_bank)) begin
          n_bad++;
          d = first_diff(coefs_active, ev);
          $display("FAIL commit_coefs cyc=%0d bank got=%b exp=%b idx=%0d", n, bank_sel, m_bank, d);
        end
      end
      if (e_ack) begin
        n_total++;
        if (addr_err !== 1'b0) begin
          n_bad++;
          $display("FAIL commit_addr_err_clear got=%b exp=0", addr_err);
        end
      end
      if ((commit_ack === 1'b1) && (ack_at < 0)) ack_at = n;
      step();
    end
    commit_req = 1'b0;
    wr_valid   = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ((coefs_active !== '0) || (bank_sel !== 1'b0) || (wr_ready !== 1'b1) || (mute !== 1'b0)) begin
      n_bad++;
      $display("FAIL reset_state bank=%b ready=%b mute=%b coefs_zero=%b exp 0/1/0/1",
               bank_sel, wr_ready, mute, coefs_active == '0);
    end
    n_total++;
    if ((busy !== 1'b0) || (commit_ack !== 1'b0) || (addr_err !== 1'b0)) begin
      n_bad++;
      $display("FAIL reset_flags busy=%b ack=%b err=%b exp=0/0/0", busy, commit_ack, addr_err);
    end
  endtask

  task automatic test_basic_commit();
    int ack_at;
    do_write(5, 18'h3FFFF);
    for (int i = 0; i < TMF && count != CWB'(TMF - 1); i++) step();
    commit_run(1'b0, ack_at);
    n_total++;
    if (ack_at != 43) begin
      n_bad++;
      $display("FAIL basic_ack_latency got=%0d exp=43", ack_at);
    end
    n_total++;
    if (coefs_active[5*CWID +: CWID] !== 18'h3FFFF) begin
      n_bad++;
      $display("FAIL basic_entry5 got=%h exp=3ffff", coefs_active[5*CWID +: CWID]);
    end
  endtask

  task automatic test_ignored_commit();
    int ack_at;
    do_write(7, 18'h0ABCD);
    for (int i = 0; i < TMF && count != CWB'(0); i++) step();
    commit_run(1'b1, ack_at);
    n_total++;
    if (ack_at != 1 + FL + 1) begin
      n_bad++;
      $display("FAIL min_ack_latency got=%0d exp=%0d", ack_at, 1 + FL + 1);
    end
  endtask

  task automatic test_addr_err();
    int ack_at;
    logic [NR*CWID-1:0] ev;
    do_write(64, 18'h15555);
    n_total++;
    if (addr_err !== 1'b1) begin
      n_bad++;
      $display("FAIL addr_err_set got=%b exp=1", addr_err);
    end
    ev = exp_vec();
    n_total++;
    if (coefs_active !== ev) begin
      n_bad++;
      $display("FAIL addr_err_active idx=%0d", first_diff(coefs_active, ev));
    end
    commit_run(1'b0, ack_at);
    n_total++;
    if (addr_err !== 1'b0) begin
      n_bad++;
      $display("FAIL addr_err_after_commit got=%b exp=0", addr_err);
    end
  endtask

  task automatic test_copyback();
    int ack_at;
    logic [CWID-1:0] e5;
`ifdef FIR_COEF_COPYBACK_EN
    e5 = 18'h3FFFF;
`else
    e5 = 18'h00000;
`endif
    do_reset();
    do_write(5, 18'h3FFFF);
    commit_run(1'b0, ack_at);
    do_write(0, 18'h00123);
    commit_run(1'b0, ack_at);
    n_total++;
    if ((coefs_active[5*CWID +: CWID] !== e5) || (coefs_active[0 +: CWID] !== 18'h00123)) begin
      n_bad++;
      $display("FAIL copyback_entries e5 got=%h exp=%h e0 got=%h exp=00123",
               coefs_active[5*CWID +: CWID], e5, coefs_active[0 +: CWID]);
    end
  endtask

  task automatic test_random();
    int ack_at;
    int addr;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < int'($urandom_range(1, 10)); i++) begin
        if ($urandom_range(0, 7) == 0) addr = int'($urandom_range(NR, 2 * NR - 1));
        else                           addr = int'($urandom_range(0, NR - 1));
        do_write(addr, CWID'($urandom));
      end
      repeat ($urandom_range(0, 3)) step();
      n_total++;
      if (addr_err !== m_err) begin
        n_bad++;
        $display("FAIL random_addr_err round=%0d got=%b exp=%b", r, addr_err, m_err);
      end
      commit_run(1'($urandom_range(0, 1)), ack_at);
    end
  endtask

  task automatic test_reset_mid_commit();
    int n_mute;
    int n_ack;
    int n_busy;
    do_write(100, 18'h00001);
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    n_total++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_pre_busy got=%b exp=1", busy);
    end
    #2;
    fir_aresetn = 1'b0;
    #1;
    model_reset();
    n_total++;
    if ((coefs_active !== '0) || (bank_sel !== 1'b0) || (wr_ready !== 1'b1) || (busy !== 1'b0) ||
        (mute !== 1'b0) || (commit_ack !== 1'b0) || (addr_err !== 1'b0)) begin
      n_bad++;
      $display("FAIL midrst_async bank=%b ready=%b busy=%b mute=%b ack=%b err=%b coefs_zero=%b exp 0/1/0/0/0/0/1",
               bank_sel, wr_ready, busy, mute, commit_ack, addr_err, coefs_active == '0);
    end
    repeat (2) step();
    fir_aresetn = 1'b1;
    n_mute = 0;
    n_ack  = 0;
    n_busy = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (mute === 1'b1)       n_mute++;
      if (commit_ack === 1'b1) n_ack++;
      if (busy === 1'b1)       n_busy++;
    end
    n_total++;
    if ((n_mute != 0) || (n_ack != 0) || (n_busy != 0)) begin
      n_bad++;
      $display("FAIL midrst_after mute=%0d ack=%0d busy=%0d exp=0/0/0", n_mute, n_ack, n_busy);
    end
  endtask

  initial begin
    fir_aresetn = 1'b0;
    count       = '0;
    wr_valid    = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    commit_req  = 1'b0;
    model_reset();
    test_reset();
    test_basic_commit();
    test_ignored_commit();
    test_addr_err();
    test_copyback();
    test_random();
    test_reset_mid_commit();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
